// File: rtl/reset_seq_pkg.sv
// Shared types and default timing constants for the reset sequencer.
package reset_seq_pkg;

  // Sequencer states; the encoding is visible on state_o.
  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    RELEASE   = 2'd2,
    RUN       = 2'd3
  } seq_state_e;

  localparam int DEF_LOCK_STABLE_CYCLES = 1024;
  localparam int DEF_STAGE_DELAY        = 256;

  // Larger of two integers; used to size the shared interval counter.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level signal.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Shift the input through two flops; both clear to 0 on reset.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/reset_sequencer.sv
// Reset sequencer: qualifies clock-generator lock, then releases
// downstream reset domains one at a time, index 0 first.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int NUM_OUT            = 2,
  parameter int LOCK_STABLE_CYCLES = DEF_LOCK_STABLE_CYCLES,
  parameter int STAGE_DELAY        = DEF_STAGE_DELAY
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               locked_i,
  input  logic               restart_i,
  output logic [NUM_OUT-1:0] rst_out_n,
  output logic               ready_o,
  output logic [7:0]         lost_cnt_o,
  output logic [1:0]         state_o
);

  // One counter serves both the lock-qualification and stage intervals.
  localparam int CNT_MAX = max_int(LOCK_STABLE_CYCLES, STAGE_DELAY);
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int IDX_W   = $clog2(NUM_OUT + 1);

  localparam logic [CNT_W-1:0] LOCK_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAGE_LAST = CNT_W'(STAGE_DELAY - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_OUT - 1);

  seq_state_e         state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [IDX_W-1:0]   idx_q;
  logic [NUM_OUT-1:0] rst_out_q;
  logic               ready_q;
  logic [7:0]         lost_q;
  logic               locked_s;
  logic               abort;

  sync_2ff u_lock_sync (
    .clk   (clk),
    .rst_n (rst),
    .d_i   (locked_i),
    .q_o   (locked_s)
  );

  // Lock loss or restart aborts the sequence in every state but WAIT_LOCK.
  assign abort = (state_q != WAIT_LOCK) && (!locked_s || restart_i);

  // Sequencer FSM with registered outputs; reset clears the domain resets asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= WAIT_LOCK;
      cnt_q     <= '0;
      idx_q     <= '0;
      rst_out_q <= '0;
      ready_q   <= 1'b0;
      lost_q    <= '0;
    end else if (abort) begin
      state_q   <= WAIT_LOCK;
      cnt_q     <= '0;
      idx_q     <= '0;
      rst_out_q <= '0;
      ready_q   <= 1'b0;
      // Lock loss wins over a simultaneous restart and counts exactly once.
      if (!locked_s && (lost_q != 8'hFF)) begin
        lost_q <= lost_q + 8'd1;
      end
    end else begin
      case (state_q)
        WAIT_LOCK: begin
          if (locked_s) begin
            state_q <= STABLE;
            cnt_q   <= '0;
          end
        end
        STABLE: begin
          if (cnt_q == LOCK_LAST) begin
            state_q <= RELEASE;
            cnt_q   <= '0;
            idx_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        RELEASE: begin
          if (cnt_q == STAGE_LAST) begin
            for (int k = 0; k < NUM_OUT; k++) begin
              if (idx_q == IDX_W'(k)) begin
                rst_out_q[k] <= 1'b1;
              end
            end
            idx_q <= idx_q + IDX_W'(1);
            cnt_q <= '0;
            if (idx_q == IDX_LAST) begin
              state_q <= RUN;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        RUN: begin
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= WAIT_LOCK;
        end
      endcase
    end
  end

  assign rst_out_n  = rst_out_q;
  assign ready_o    = ready_q;
  assign lost_cnt_o = lost_q;
  assign state_o    = state_q;

endmodule
